vsa_mem_arbiter: RTL and testbench
==================================

// Module: vsa_mem_arbiter
// PURPOSE
//  Shares one synchronous memory port between the VSA core's instruction-fetch requester (I) and its load/store requester (D).
//  Two-way round-robin arbitration, a fixed-latency access sequencer and a single-cycle ack per access.
//  Sits between the VSA core and a unified 32-word x 12-bit memory, replacing separate I-cache/D-cache ports.
// PARAMETERS
//  MEM_LAT  2  cycles from m_en to valid m_rdata; legal range 1..7
//  CNT_W    8  width of the grant statistics counters (VSA_ARB_STATS_EN only)
// PORTS
//  clock        in   1      master clock, rising edge
//  reset        in   1      asynchronous, active-high reset
//  i_req        in   1      fetch request; held with i_addr until i_ack
//  i_addr       in   5      fetch word address
//  i_ack        out  1      one-cycle pulse: access done, i_rdata valid
//  i_rdata      out  12     fetched instruction word
//  d_req        in   1      data request; held with d_we/d_addr/d_wdata until d_ack
//  d_we         in   1      1 = store, 0 = load
//  d_addr       in   5      data word address
//  d_wdata      in   5      store data
//  d_ack        out  1      one-cycle pulse: access done, d_rdata valid for loads
//  d_rdata      out  5      load data, m_rdata[4:0]
//  m_en         out  1      memory access strobe, one cycle per access
//  m_we         out  1      memory write enable, qualified by m_en
//  m_addr       out  5      memory address
//  m_wdata      out  12     memory write data, {7'b0, d_wdata}
//  m_rdata      in   12     memory read data, valid MEM_LAT cycles after m_en
//  busy         out  1      state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, last_grant=D (first contention goes to I), all outputs 0, captured data 0.
//  - FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE, always; there is no back-to-back bypass.
//  - IDLE, arbitration and latching:
//      only one req high: that port wins;
//      both high: the port != last_grant wins;
//      neither: stay in IDLE.
//    Winner's addr, we and wdata are latched, last_grant is updated, go to ISSUE.
//  - ISSUE, one cycle: m_en=1, m_we=latched we (always 0 for I), m_addr/m_wdata from latches; wait count loaded with MEM_LAT.
//  - WAIT: exactly MEM_LAT cycles.
//    m_rdata is captured at the edge ending the last WAIT cycle; for stores the capture is suppressed and the rdata register is unchanged.
//  - RESP, one cycle: the winner's ack=1.
//    i_rdata/d_rdata are registered outputs and hold until the next capture.
//  - Latency: req seen in IDLE at cycle T -> ack in cycle T+MEM_LAT+2.
//    Minimum spacing between two acks is MEM_LAT+3 cycles.
//  - Requester drops req in the cycle after ack.
//    If req is withdrawn before ack, the latched access still completes and still acks; the arbiter never aborts.
//  - A req that arrives while busy waits for IDLE. It is not lost, because the requester holds it.
//  - Simultaneous steady requests alternate I, D, I, D; neither port waits more than one access.
//  - Reset mid-access: immediate return to IDLE, no ack, the memory strobe is dropped, the in-flight access is discarded.
// CONFIGURATION
//  VSA_ARB_STATS_EN defined:
//    adds outputs i_grant_cnt and d_grant_cnt [CNT_W-1:0];
//    each increments in the ISSUE cycle of its port, saturates at all-ones, resets to 0.
//  VSA_ARB_STATS_EN undefined: the counters and those ports do not exist; all other behaviour is identical.
// STRUCTURE
//  - Package vsa_arb_pkg: ADDR_W=5, WORD_W=12, DATA_W=5; typedef enum arb_state_t {IDLE, ISSUE, WAIT, RESP}; typedef enum port_t {PORT_I, PORT_D}.
//  - Sub-module vsa_rr_pick: combinational 2-way round-robin picker (req_i, req_d, last -> grant, valid).
//  - Top holds the FSM, the wait counter, the latches and the optional statistics counters.
// TESTING
//  - Reset then i_req=1, i_addr=5'h03, memory returns 12'h6A5 (MEM_LAT=2): m_en in cycle T+1 with m_addr=3, i_ack in T+4, i_rdata=12'h6A5.
//  - d_req=1, d_we=1, d_addr=5'h1F, d_wdata=5'h15: m_we=1, m_wdata=12'h015 in ISSUE; d_ack in T+4; d_rdata unchanged.
//  - i_req and d_req both high from reset, held for 4 accesses: grant order I, D, I, D; ack spacing 5 cycles.
//  - d_req asserted during an I access: D issues in the first ISSUE after the I RESP, with no extra delay.
//  - Assert reset during WAIT: busy=0 immediately, no ack ever issued, next request served normally.
//  - With VSA_ARB_STATS_EN and CNT_W=2, run 5 fetches: i_grant_cnt saturates at 3, d_grant_cnt=0.

Source files
------------

// File: rtl/vsa_arb_pkg.sv
// ============================================================================
// Module : vsa_arb_pkg
// Brief  : Shared widths and enumerations for the VSA memory arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package vsa_arb_pkg;

    localparam int ADDR_W = 5;
    localparam int WORD_W = 12;
    localparam int DATA_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_t;

endpackage

`default_nettype wire

// File: rtl/vsa_rr_pick.sv
// ============================================================================
// Module : vsa_rr_pick
// Brief  : Combinational two-way round-robin picker (I vs D requester).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module vsa_rr_pick
    import vsa_arb_pkg::*;
(
    input  logic  req_i,
    input  logic  req_d,
    input  port_t last,
    output port_t grant,
    output logic  valid
);

    always_comb begin
        valid = req_i | req_d;
        grant = PORT_I;
        if (req_i && req_d) begin
            // Contention goes to whichever port did not win last time.
            grant = (last == PORT_I) ? PORT_D : PORT_I;
        end else if (req_d) begin
            grant = PORT_D;
        end
    end

endmodule

`default_nettype wire

// File: rtl/vsa_mem_arbiter.sv
// ============================================================================
// Module : vsa_mem_arbiter
// Brief  : Round-robin sharing of one fixed-latency memory port between the
//          fetch (I) and load/store (D) requesters. Optional grant statistics
//          are enabled by defining VSA_ARB_STATS_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module vsa_mem_arbiter
    import vsa_arb_pkg::*;
#(
    parameter int MEM_LAT = 2
`ifdef VSA_ARB_STATS_EN
    ,
    parameter int CNT_W   = 8
`endif
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [WORD_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [WORD_W-1:0] m_wdata,
    input  logic [WORD_W-1:0] m_rdata,
    output logic              busy
`ifdef VSA_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]  i_grant_cnt,
    output logic [CNT_W-1:0]  d_grant_cnt
`endif
);

    arb_state_t        r_state;
    arb_state_t        w_next;
    port_t             r_port;
    port_t             r_last;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [2:0]        r_cnt;
    logic [WORD_W-1:0] r_rdata;
    port_t             w_grant;
    logic              w_valid;
    logic              w_last_wait;

    vsa_rr_pick u_pick (
        .req_i (i_req),
        .req_d (d_req),
        .last  (r_last),
        .grant (w_grant),
        .valid (w_valid)
    );

    assign w_last_wait = (r_state == WAIT) && (r_cnt == 3'd1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_valid) w_next = ISSUE;
            ISSUE:   w_next = WAIT;
            WAIT:    if (r_cnt == 3'd1) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        m_en    = (r_state == ISSUE);
        m_we    = (r_state == ISSUE) && r_we;
        m_addr  = (r_state == ISSUE) ? r_addr : '0;
        m_wdata = (r_state == ISSUE) ? {{(WORD_W-DATA_W){1'b0}}, r_wdata} : '0;
        i_ack   = (r_state == RESP) && (r_port == PORT_I);
        d_ack   = (r_state == RESP) && (r_port == PORT_D);
        busy    = (r_state != IDLE);
    end

    // Winner's request is latched so a withdrawn req still completes cleanly.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_port  <= PORT_I;
            r_last  <= PORT_D;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (r_state == IDLE && w_valid) begin
            r_port  <= w_grant;
            r_last  <= w_grant;
            r_we    <= (w_grant == PORT_D) && d_we;
            r_addr  <= (w_grant == PORT_D) ? d_addr : i_addr;
            r_wdata <= (w_grant == PORT_D) ? d_wdata : '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_rdata <= '0;
        end else begin
            if (r_state == ISSUE)     r_cnt <= 3'(MEM_LAT);
            else if (r_state == WAIT) r_cnt <= r_cnt - 3'd1;
            if (w_last_wait && !r_we) r_rdata <= m_rdata;
        end
    end

    assign i_rdata = r_rdata;
    assign d_rdata = r_rdata[DATA_W-1:0];

`ifdef VSA_ARB_STATS_EN
    logic [CNT_W-1:0] r_i_cnt;
    logic [CNT_W-1:0] r_d_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_i_cnt <= '0;
            r_d_cnt <= '0;
        end else if (r_state == ISSUE) begin
            if (r_port == PORT_I && r_i_cnt != '1) r_i_cnt <= r_i_cnt + CNT_W'(1);
            if (r_port == PORT_D && r_d_cnt != '1) r_d_cnt <= r_d_cnt + CNT_W'(1);
        end
    end

    assign i_grant_cnt = r_i_cnt;
    assign d_grant_cnt = r_d_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vsa_mem_arbiter.sv
// ============================================================================
// Module : tb_vsa_mem_arbiter
// Brief  : Directed self-checking bench for vsa_mem_arbiter (MEM_LAT = 2).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_vsa_mem_arbiter;
    import vsa_arb_pkg::*;

    localparam int MEM_LAT = 2;

    logic              clock = 1'b0;
    logic              reset;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic [WORD_W-1:0] i_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic              m_en;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [WORD_W-1:0] m_wdata;
    logic [WORD_W-1:0] m_rdata;
    logic              busy;
`ifdef VSA_ARB_STATS_EN
    logic [1:0]        i_grant_cnt;
    logic [1:0]        d_grant_cnt;
`endif

    int checks = 0;
    int errors = 0;

    vsa_mem_arbiter #(
        .MEM_LAT (MEM_LAT)
`ifdef VSA_ARB_STATS_EN
        ,
        .CNT_W   (2)
`endif
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_ack   (i_ack),
        .i_rdata (i_rdata),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_ack   (d_ack),
        .d_rdata (d_rdata),
        .m_en    (m_en),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .busy    (busy)
`ifdef VSA_ARB_STATS_EN
        ,
        .i_grant_cnt (i_grant_cnt),
        .d_grant_cnt (d_grant_cnt)
`endif
    );

    always #5 clock = ~clock;

    // Memory model: read data appears exactly MEM_LAT cycles after m_en,
    // otherwise a poison pattern so mistimed captures are visible.
    logic [WORD_W-1:0] mem  [32];
    logic [WORD_W-1:0] pipe [MEM_LAT];

    initial begin
        for (int i = 0; i < 32; i++) mem[i] <= 12'h000;
        for (int i = 0; i < MEM_LAT; i++) pipe[i] <= 12'hBAD;
        mem[3]  <= 12'h6A5;
        mem[2]  <= 12'h123;
        mem[4]  <= 12'h0F7;
        mem[31] <= 12'h00A;
    end

    always @(posedge clock) begin
        if (m_en && m_we) mem[m_addr] <= m_wdata;
        pipe[0] <= (m_en && !m_we) ? mem[m_addr] : 12'hBAD;
        for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
    end

    assign m_rdata = pipe[MEM_LAT-1];

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1; i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        tick(); tick();
        checks++;
        if ({i_ack, d_ack, m_en, m_we, busy} !== 5'b0 || m_addr !== 5'h00 ||
            m_wdata !== 12'h000 || i_rdata !== 12'h000 || d_rdata !== 5'h00) begin
            errors++;
            $display("FAIL reset_outputs: ack=%b%b m_en=%b m_we=%b busy=%b m_addr=%h m_wdata=%h i_rdata=%h d_rdata=%h, required all 0",
                     i_ack, d_ack, m_en, m_we, busy, m_addr, m_wdata, i_rdata, d_rdata);
        end
`ifdef VSA_ARB_STATS_EN
        checks++;
        if (i_grant_cnt !== 2'd0 || d_grant_cnt !== 2'd0) begin
            errors++;
            $display("FAIL reset_stats: i=%0d d=%0d, required 0 0", i_grant_cnt, d_grant_cnt);
        end
`endif
        reset = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_fetch();
        i_req = 1'b1; i_addr = 5'h03;
        tick();
        checks++;
        if (m_en !== 1'b1 || m_we !== 1'b0 || m_addr !== 5'h03 || busy !== 1'b1) begin
            errors++;
            $display("FAIL fetch_issue: m_en=%b m_we=%b m_addr=%h busy=%b, required 1 0 03 1", m_en, m_we, m_addr, busy);
        end
        tick();
        checks++;
        if (m_en !== 1'b0 || i_ack !== 1'b0) begin
            errors++;
            $display("FAIL fetch_wait1: m_en=%b i_ack=%b, required 0 0", m_en, i_ack);
        end
        tick();
        checks++;
        if (i_ack !== 1'b0) begin
            errors++;
            $display("FAIL fetch_wait2: i_ack=%b, required 0", i_ack);
        end
        tick();
        checks++;
        if (i_ack !== 1'b1 || d_ack !== 1'b0 || i_rdata !== 12'h6A5) begin
            errors++;
            $display("FAIL fetch_ack: i_ack=%b d_ack=%b i_rdata=%h, required 1 0 6a5", i_ack, d_ack, i_rdata);
        end
        i_req = 1'b0;
        tick();
        checks++;
        if (i_ack !== 1'b0 || busy !== 1'b0 || i_rdata !== 12'h6A5) begin
            errors++;
            $display("FAIL fetch_after: i_ack=%b busy=%b i_rdata=%h, required 0 0 6a5", i_ack, busy, i_rdata);
        end
    endtask

    task automatic test_load_store();
        d_req = 1'b1; d_we = 1'b0; d_addr = 5'h1F;
        repeat (4) tick();
        checks++;
        if (d_ack !== 1'b1 || d_rdata !== 5'h0A) begin
            errors++;
            $display("FAIL load_ack: d_ack=%b d_rdata=%h, required 1 0a", d_ack, d_rdata);
        end
        d_req = 1'b0;
        tick();
        d_req = 1'b1; d_we = 1'b1; d_wdata = 5'h15;
        tick();
        checks++;
        if (m_en !== 1'b1 || m_we !== 1'b1 || m_addr !== 5'h1F || m_wdata !== 12'h015) begin
            errors++;
            $display("FAIL store_issue: m_en=%b m_we=%b m_addr=%h m_wdata=%h, required 1 1 1f 015", m_en, m_we, m_addr, m_wdata);
        end
        repeat (3) tick();
        checks++;
        if (d_ack !== 1'b1 || i_ack !== 1'b0 || d_rdata !== 5'h0A) begin
            errors++;
            $display("FAIL store_ack: d_ack=%b i_ack=%b d_rdata=%h, required 1 0 0a", d_ack, i_ack, d_rdata);
        end
        d_req = 1'b0; d_we = 1'b0;
        tick();
        d_req = 1'b1;
        repeat (4) tick();
        checks++;
        if (d_ack !== 1'b1 || d_rdata !== 5'h15) begin
            errors++;
            $display("FAIL load_back: d_ack=%b d_rdata=%h, required 1 15", d_ack, d_rdata);
        end
        d_req = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        logic exp_i, exp_d;
        reset = 1'b1;
        i_req = 1'b1; i_addr = 5'h02;
        d_req = 1'b1; d_we = 1'b0; d_addr = 5'h04;
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            exp_i = (k == 4) || (k == 14);
            exp_d = (k == 9) || (k == 19);
            checks++;
            if (i_ack !== exp_i || d_ack !== exp_d) begin
                errors++;
                $display("FAIL rr_ack k=%0d: i_ack=%b d_ack=%b, required %b %b", k, i_ack, d_ack, exp_i, exp_d);
            end
            if (k == 1 || k == 6 || k == 11 || k == 16) begin
                checks++;
                if (m_en !== 1'b1 || m_addr !== ((k == 1 || k == 11) ? 5'h02 : 5'h04)) begin
                    errors++;
                    $display("FAIL rr_issue k=%0d: m_en=%b m_addr=%h", k, m_en, m_addr);
                end
            end
            if (k == 9) begin
                checks++;
                if (d_rdata !== 5'h17) begin
                    errors++;
                    $display("FAIL rr_dload: d_rdata=%h, required 17", d_rdata);
                end
            end
            if (k == 14) begin
                checks++;
                if (i_rdata !== 12'h123) begin
                    errors++;
                    $display("FAIL rr_fetch: i_rdata=%h, required 123", i_rdata);
                end
            end
            if (k == 19) begin
                i_req = 1'b0; d_req = 1'b0;
            end
        end
    endtask

    task automatic test_late_d();
        i_req = 1'b1; i_addr = 5'h03;
        tick(); tick();
        d_req = 1'b1; d_we = 1'b0; d_addr = 5'h04;
        tick(); tick();
        checks++;
        if (i_ack !== 1'b1 || d_ack !== 1'b0) begin
            errors++;
            $display("FAIL late_i_ack: i_ack=%b d_ack=%b, required 1 0", i_ack, d_ack);
        end
        i_req = 1'b0;
        tick();
        checks++;
        if (m_en !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL late_idle: m_en=%b busy=%b, required 0 0", m_en, busy);
        end
        tick();
        checks++;
        if (m_en !== 1'b1 || m_addr !== 5'h04) begin
            errors++;
            $display("FAIL late_d_issue: m_en=%b m_addr=%h, required 1 04", m_en, m_addr);
        end
        repeat (3) tick();
        checks++;
        if (d_ack !== 1'b1 || d_rdata !== 5'h17) begin
            errors++;
            $display("FAIL late_d_ack: d_ack=%b d_rdata=%h, required 1 17", d_ack, d_rdata);
        end
        d_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        int acks;
        i_req = 1'b1; i_addr = 5'h03;
        tick(); tick();
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || m_en !== 1'b0 || i_ack !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: busy=%b m_en=%b i_ack=%b, required 0 0 0", busy, m_en, i_ack);
        end
        i_req = 1'b0;
        tick();
        reset = 1'b0;
        acks = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (i_ack || d_ack || m_en) acks++;
        end
        checks++;
        if (acks !== 0) begin
            errors++;
            $display("FAIL mid_no_ack: activity cycles=%0d, required 0", acks);
        end
        i_req = 1'b1; i_addr = 5'h02;
        repeat (4) tick();
        checks++;
        if (i_ack !== 1'b1 || i_rdata !== 12'h123) begin
            errors++;
            $display("FAIL mid_recover: i_ack=%b i_rdata=%h, required 1 123", i_ack, i_rdata);
        end
        i_req = 1'b0;
        tick();
    endtask

`ifdef VSA_ARB_STATS_EN
    task automatic test_stats();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int n = 0; n < 5; n++) begin
            i_req = 1'b1; i_addr = 5'h03;
            repeat (4) tick();
            i_req = 1'b0;
            tick();
        end
        checks++;
        if (i_grant_cnt !== 2'd3 || d_grant_cnt !== 2'd0) begin
            errors++;
            $display("FAIL stats_sat: i=%0d d=%0d, required 3 0", i_grant_cnt, d_grant_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fetch();
        test_load_store();
        test_round_robin();
        test_late_d();
        test_reset_mid();
`ifdef VSA_ARB_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
